// File: rtl/vc_flit_buffer_if.sv
// vc_flit_buffer_if
// Groups every signal between an upstream producer/consumer and the
// multi-virtual-channel flit buffer. Clock and reset are not part of the
// bundle; they stay plain ports on the buffer.
//
// Handshake: there is no ready signal. A push (wr_en) is accepted on the
// rising edge only when full[wr_vc] was 0 before that edge. A pop (rd_en)
// is accepted only when empty[rd_vc] was 0 before that edge. An accepted
// pop shows up one cycle later as rd_valid=1 together with rd_data,
// rd_data_vc and a credit_out pulse for that VC. Rejected requests change
// no state apart from setting the sticky ovf_err / udf_err flags.
//
// Modports:
//   master : upstream side, drives wr_*, rd_en, rd_vc, err_clr
//   slave  : buffer side, drives rd_data, rd_valid, rd_data_vc, full,
//            empty, count, credit_out, ovf_err, udf_err
interface vc_flit_buffer_if #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 8,
    parameter int NUM_VC     = 2
);
    localparam int VC_W  = $clog2(NUM_VC);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic                    wr_en;
    logic [VC_W-1:0]         wr_vc;
    logic [DATA_WIDTH-1:0]   wr_data;
    logic                    rd_en;
    logic [VC_W-1:0]         rd_vc;
    logic [DATA_WIDTH-1:0]   rd_data;
    logic                    rd_valid;
    logic [VC_W-1:0]         rd_data_vc;
    logic [NUM_VC-1:0]       full;
    logic [NUM_VC-1:0]       empty;
    logic [NUM_VC*CNT_W-1:0] count;
    logic [NUM_VC-1:0]       credit_out;
    logic                    ovf_err;
    logic                    udf_err;
    logic                    err_clr;

    modport master (
        output wr_en, wr_vc, wr_data, rd_en, rd_vc, err_clr,
        input  rd_data, rd_valid, rd_data_vc, full, empty, count,
               credit_out, ovf_err, udf_err
    );

    modport slave (
        input  wr_en, wr_vc, wr_data, rd_en, rd_vc, err_clr,
        output rd_data, rd_valid, rd_data_vc, full, empty, count,
               credit_out, ovf_err, udf_err
    );
endinterface

// File: rtl/vc_flit_buffer.sv
// vc_flit_buffer
// Input-port flit buffer for the mesh router: NUM_VC independent FIFOs of
// DEPTH flits each, sharing one flat storage array addressed as
// {vc, ptr}. Provides per-VC full/empty/occupancy, a one-cycle credit pulse
// per successful pop, and sticky overflow/underflow error flags.
//
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset (storage contents are not reset)
//   bus   : vc_flit_buffer_if.slave -- push/pop requests, registered read
//           data, status flags, credits and error flags
module vc_flit_buffer #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 8,
    parameter int NUM_VC     = 2
) (
    input logic             clk,
    input logic             rst_n,
    vc_flit_buffer_if.slave bus
);
    localparam int AW    = $clog2(DEPTH);
    localparam int VC_W  = $clog2(NUM_VC);
    localparam int CNT_W = AW + 1;

    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
    localparam logic [AW-1:0]    PTR_ONE  = AW'(1);

    logic [DATA_WIDTH-1:0] mem [NUM_VC*DEPTH];
    logic [AW-1:0]         wptr [NUM_VC];
    logic [AW-1:0]         rptr [NUM_VC];
    logic [CNT_W-1:0]      cnt  [NUM_VC];

    logic [NUM_VC-1:0] full_vec;
    logic [NUM_VC-1:0] empty_vec;
    logic [NUM_VC-1:0] inc_vec;
    logic [NUM_VC-1:0] dec_vec;
    logic              push_ok;
    logic              pop_ok;
    logic              push_rej;
    logic              pop_rej;

    // Status flags come straight from the registered occupancy counters.
    always_comb begin
        full_vec  = '0;
        empty_vec = '0;
        bus.count = '0;
        for (int v = 0; v < NUM_VC; v++) begin
            full_vec[v]                = (cnt[v] == CNT_FULL);
            empty_vec[v]               = (cnt[v] == '0);
            bus.count[v*CNT_W +: CNT_W] = cnt[v];
        end
    end

    assign bus.full  = full_vec;
    assign bus.empty = empty_vec;

    // Acceptance is judged on the pre-edge flags, so a push into an empty
    // VC never satisfies a pop of the same VC in the same cycle.
    always_comb begin
        push_ok  = bus.wr_en && !full_vec[bus.wr_vc];
        pop_ok   = bus.rd_en && !empty_vec[bus.rd_vc];
        push_rej = bus.wr_en && full_vec[bus.wr_vc];
        pop_rej  = bus.rd_en && empty_vec[bus.rd_vc];
        inc_vec  = '0;
        dec_vec  = '0;
        if (push_ok) inc_vec[bus.wr_vc] = 1'b1;
        if (pop_ok)  dec_vec[bus.rd_vc] = 1'b1;
    end

    // Storage has no reset; stale contents are unreachable once the
    // pointers and counters are cleared.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[{bus.wr_vc, wptr[bus.wr_vc]}] <= bus.wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int v = 0; v < NUM_VC; v++) begin
                wptr[v] <= '0;
                rptr[v] <= '0;
                cnt[v]  <= '0;
            end
        end else begin
            for (int v = 0; v < NUM_VC; v++) begin
                if (inc_vec[v]) wptr[v] <= wptr[v] + PTR_ONE;
                if (dec_vec[v]) rptr[v] <= rptr[v] + PTR_ONE;
                // Simultaneous push and pop on one VC leaves the count as is.
                case ({inc_vec[v], dec_vec[v]})
                    2'b10:   cnt[v] <= cnt[v] + CNT_ONE;
                    2'b01:   cnt[v] <= cnt[v] - CNT_ONE;
                    default: cnt[v] <= cnt[v];
                endcase
            end
        end
    end

    // Registered read port: rd_data holds its last flit when nothing pops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.rd_data    <= '0;
            bus.rd_valid   <= 1'b0;
            bus.rd_data_vc <= '0;
            bus.credit_out <= '0;
        end else begin
            bus.rd_valid   <= pop_ok;
            bus.credit_out <= dec_vec;
            if (pop_ok) begin
                bus.rd_data    <= mem[{bus.rd_vc, rptr[bus.rd_vc]}];
                bus.rd_data_vc <= bus.rd_vc;
            end
        end
    end

    // Sticky error flags; a new error in the same cycle beats err_clr.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.ovf_err <= 1'b0;
            bus.udf_err <= 1'b0;
        end else begin
            if (push_rej)         bus.ovf_err <= 1'b1;
            else if (bus.err_clr) bus.ovf_err <= 1'b0;
            if (pop_rej)          bus.udf_err <= 1'b1;
            else if (bus.err_clr) bus.udf_err <= 1'b0;
        end
    end
endmodule

// File: tb/tb_vc_flit_buffer.sv
// tb_vc_flit_buffer
// Directed bench for vc_flit_buffer with a per-VC reference FIFO model and
// an expected-output queue consumed whenever rd_valid is expected.
module tb_vc_flit_buffer;
    localparam int DW     = 32;
    localparam int DEPTH  = 8;
    localparam int NUM_VC = 2;
    localparam int VC_W   = $clog2(NUM_VC);
    localparam int CNT_W  = $clog2(DEPTH) + 1;
    localparam int W      = VC_W + DW;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    vc_flit_buffer_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .NUM_VC(NUM_VC)) bus ();

    vc_flit_buffer #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .NUM_VC(NUM_VC)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // ---------------- reference model / scoreboard ----------------
    logic [DW-1:0] mq0[$];
    logic [DW-1:0] mq1[$];
    logic [W-1:0]  exp_q[$];
    logic          exp_valid   = 1'b0;
    logic          exp_ovf     = 1'b0;
    logic          exp_udf     = 1'b0;
    logic [DW-1:0] exp_rd_data = '0;
    logic [VC_W-1:0] exp_rd_vc = '0;
    int n_vec  = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic int qsize(input logic [VC_W-1:0] vc);
        return (vc == 1'b1) ? mq1.size() : mq0.size();
    endfunction

    // ---------------- driver tasks ----------------
    task automatic step(input logic we, input logic [VC_W-1:0] wv, input logic [DW-1:0] wd,
                        input logic re, input logic [VC_W-1:0] rv, input logic ec);
        int  wsz;
        int  rsz;
        logic push_ok;
        logic pop_ok;
        logic [DW-1:0] d;
        bus.wr_en   = we;
        bus.wr_vc   = wv;
        bus.wr_data = wd;
        bus.rd_en   = re;
        bus.rd_vc   = rv;
        bus.err_clr = ec;
        wsz = qsize(wv);
        rsz = qsize(rv);
        push_ok = we && (wsz < DEPTH);
        pop_ok  = re && (rsz != 0);
        @(posedge clk);
        #1;
        if (pop_ok) begin
            d = (rv == 1'b1) ? mq1.pop_front() : mq0.pop_front();
            exp_q.push_back({rv, d});
        end
        if (push_ok) begin
            if (wv == 1'b1) mq1.push_back(wd);
            else            mq0.push_back(wd);
        end
        exp_valid = pop_ok;
        if (we && wsz >= DEPTH) exp_ovf = 1'b1;
        else if (ec)            exp_ovf = 1'b0;
        if (re && rsz == 0)     exp_udf = 1'b1;
        else if (ec)            exp_udf = 1'b0;
        bus.wr_en   = 1'b0;
        bus.rd_en   = 1'b0;
        bus.err_clr = 1'b0;
    endtask

    task automatic push(input logic [VC_W-1:0] vc, input logic [DW-1:0] d);
        step(1'b1, vc, d, 1'b0, '0, 1'b0);
    endtask

    task automatic pop(input logic [VC_W-1:0] vc);
        step(1'b0, '0, '0, 1'b1, vc, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, '0, 1'b0, '0, 1'b0);
    endtask

    task automatic model_reset();
        mq0.delete();
        mq1.delete();
        exp_q.delete();
        exp_valid   = 1'b0;
        exp_ovf     = 1'b0;
        exp_udf     = 1'b0;
        exp_rd_data = '0;
        exp_rd_vc   = '0;
    endtask

    // ---------------- output monitor (opposite edge) ----------------
    always @(negedge clk) begin
        logic [W-1:0] e;
        logic [NUM_VC-1:0] exp_credit;
        check("rd_valid", 64'(bus.rd_valid), 64'(exp_valid));
        exp_credit = '0;
        if (exp_valid) begin
            if (exp_q.size() == 0) begin
                check("exp_q_underrun", 64'd1, 64'd0);
            end else begin
                e = exp_q.pop_front();
                exp_rd_data = e[DW-1:0];
                exp_rd_vc   = e[W-1:DW];
                exp_credit[exp_rd_vc] = 1'b1;
            end
        end
        check("rd_data",    64'(bus.rd_data),    64'(exp_rd_data));
        check("rd_data_vc", 64'(bus.rd_data_vc), 64'(exp_rd_vc));
        check("credit_out", 64'(bus.credit_out), 64'(exp_credit));
        check("count",      64'(bus.count), 64'({CNT_W'(mq1.size()), CNT_W'(mq0.size())}));
        check("full",       64'(bus.full),  64'({mq1.size() == DEPTH, mq0.size() == DEPTH}));
        check("empty",      64'(bus.empty), 64'({mq1.size() == 0, mq0.size() == 0}));
        check("ovf_err",    64'(bus.ovf_err), 64'(exp_ovf));
        check("udf_err",    64'(bus.udf_err), 64'(exp_udf));
    end

    // ---------------- directed sequence ----------------
    initial begin
        bus.wr_en   = 1'b0;
        bus.wr_vc   = '0;
        bus.wr_data = '0;
        bus.rd_en   = 1'b0;
        bus.rd_vc   = '0;
        bus.err_clr = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // reset state
        check("rst_count", 64'(bus.count), 64'd0);
        check("rst_empty", 64'(bus.empty), 64'b11);
        check("rst_full",  64'(bus.full),  64'd0);
        check("rst_rd_data", 64'(bus.rd_data), 64'd0);

        // fill VC0, then overflow
        for (int i = 0; i < 8; i++) push(1'b0, DW'(i));
        check("fill_full0",  64'(bus.full[0]), 64'd1);
        check("fill_count0", 64'(bus.count[CNT_W-1:0]), 64'd8);
        check("fill_empty1", 64'(bus.empty[1]), 64'd1);
        push(1'b0, 32'hFF);
        check("ovf_set",    64'(bus.ovf_err), 64'd1);
        check("ovf_count0", 64'(bus.count[CNT_W-1:0]), 64'd8);
        step(1'b0, '0, '0, 1'b0, '0, 1'b1);
        check("ovf_clr", 64'(bus.ovf_err), 64'd0);

        // drain VC0 back-to-back: expect 0..7 in order
        for (int i = 0; i < 8; i++) pop(1'b0);
        idle(1);
        check("drain_empty0", 64'(bus.empty[0]), 64'd1);

        // interleaved VCs, alternating pops
        for (int i = 0; i < 4; i++) begin
            push(1'b0, DW'(20 * i));
            push(1'b1, DW'(100 + i));
        end
        for (int i = 0; i < 4; i++) begin
            pop(1'b1);
            pop(1'b0);
        end
        idle(1);

        // steady-state push+pop on VC1 across pointer wrap
        for (int i = 0; i < 3; i++) push(1'b1, DW'(200 + i));
        for (int i = 0; i < 10; i++) step(1'b1, 1'b1, DW'(210 + i), 1'b1, 1'b1, 1'b0);
        check("wrap_count1", 64'(bus.count[2*CNT_W-1:CNT_W]), 64'd3);
        for (int i = 0; i < 3; i++) pop(1'b1);
        idle(1);

        // pop empty VC0 while pushing to it: push wins, pop rejected
        step(1'b1, 1'b0, 32'hA5, 1'b1, 1'b0, 1'b0);
        check("udf_valid",  64'(bus.rd_valid), 64'd0);
        check("udf_set",    64'(bus.udf_err), 64'd1);
        check("udf_count0", 64'(bus.count[CNT_W-1:0]), 64'd1);
        pop(1'b0);
        check("a5_data", 64'(bus.rd_data), 64'hA5);
        step(1'b0, '0, '0, 1'b0, '0, 1'b1);
        check("udf_clr", 64'(bus.udf_err), 64'd0);

        // asynchronous reset mid-burst
        for (int i = 0; i < 3; i++) push(1'b0, DW'(300 + i));
        for (int i = 0; i < 3; i++) push(1'b1, DW'(400 + i));
        pop(1'b0);
        #1;
        rst_n = 1'b0;
        model_reset();
        #1;
        check("arst_valid", 64'(bus.rd_valid), 64'd0);
        check("arst_count", 64'(bus.count), 64'd0);
        check("arst_empty", 64'(bus.empty), 64'b11);
        idle(2);
        rst_n = 1'b1;
        push(1'b1, 32'h77);
        pop(1'b1);
        check("post_rst_data", 64'(bus.rd_data), 64'h77);
        idle(2);

        check("exp_q_drained", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule

// File: doc/vc_flit_buffer.md
Name: vc_flit_buffer

Overview:
- Parametrised single-clock, multi-virtual-channel flit buffer for the 2x4 mesh NoC router input port.
- Next generation of the fixed 8x32 dual-port RAM: storage is generalised in width, depth and channel count.
- NUM_VC independent FIFO queues share one flat storage array.
- Adds per-VC full/empty/occupancy, credit return to the upstream router, and sticky overflow/underflow error flags.

Parameters:
DATA_WIDTH, 32, flit width in bits
DEPTH, 8, entries per VC; power of two, at least 2
NUM_VC, 2, number of virtual channels; power of two, at least 2
VC_W, log2(NUM_VC), VC index width (derived)
CNT_W, log2(DEPTH)+1, occupancy counter width (derived)

Ports:
clk  input  1  single clock, rising-edge
rst_n  input  1  asynchronous active-low reset
wr_en  input  1  push request
wr_vc  input  VC_W  target VC for push
wr_data  input  DATA_WIDTH  flit to push
rd_en  input  1  pop request
rd_vc  input  VC_W  source VC for pop
rd_data  output  DATA_WIDTH  popped flit, registered
rd_valid  output  1  rd_data holds a flit popped in the previous cycle
rd_data_vc  output  VC_W  VC that rd_data came from
full  output  NUM_VC  per-VC full flags
empty  output  NUM_VC  per-VC empty flags
count  output  NUM_VC*CNT_W  per-VC occupancy; VC k occupies bits [k*CNT_W +: CNT_W]
credit_out  output  NUM_VC  one-cycle pulse per successful pop, one bit per VC
ovf_err  output  1  sticky flag: push to a full VC was attempted
udf_err  output  1  sticky flag: pop from an empty VC was attempted
err_clr  input  1  synchronous clear of ovf_err and udf_err

Behaviour:
- Clock and reset: one clock `clk`; reset `rst_n` is asynchronous, active-low.
- Reset values:
  - All per-VC write and read pointers = 0.
  - count = 0, empty = all 1s, full = all 0s.
  - rd_data = 0, rd_valid = 0, rd_data_vc = 0, credit_out = 0.
  - ovf_err = 0, udf_err = 0.
  - Storage contents are not reset.
- Reset mid-operation discards all queued flits. An in-flight rd_valid drops immediately.
- Storage addressing: physical address = {vc, ptr[log2(DEPTH)-1:0]}, giving a total of NUM_VC*DEPTH entries.
- Pointers wrap modulo DEPTH. full and empty are derived from count; count == DEPTH means full.
- Push: accepted when wr_en=1 and full[wr_vc]=0, judged on the pre-edge flag.
  - On acceptance: write mem[{wr_vc, wptr[wr_vc]}], then increment that wptr.
  - When wr_en=1 and the VC is full: no write, no pointer change, ovf_err set.
- Pop: accepted when rd_en=1 and empty[rd_vc]=0, judged on the pre-edge flag.
  - On acceptance, the next cycle shows rd_data = mem[{rd_vc, rptr[rd_vc]}], rd_valid = 1, rd_data_vc = rd_vc. Read latency is exactly 1 cycle.
  - rptr increments.
  - credit_out[rd_vc] pulses 1 in the same cycle as rd_valid.
- Rejected pop: when rd_en=1 and the VC is empty, no pop, rd_valid = 0 next cycle, udf_err set.
- Hold behaviour: when no pop occurs, rd_data holds its last value and rd_valid = 0.
- Simultaneous push and pop:
  - Different VCs: both proceed independently. Each count changes by ±1.
  - Same VC, neither full nor empty: both proceed, count unchanged.
  - Same VC, empty: the push is accepted; the pop is rejected and udf_err is set. There is no write-to-read bypass.
  - Same VC, full: the pop is accepted; the push is rejected and ovf_err is set. Upstream must obey credits.
- Error flags:
  - Once set, ovf_err and udf_err stay at 1 until err_clr=1 or reset.
  - If err_clr and a new error occur in the same cycle, the set wins.
- Combinational paths: none from inputs to outputs. All outputs are registered or derived from registered count/pointers.

Test Plan:
- Reset, then push 0,1,…,7 to VC0 on consecutive cycles → full[0]=1, count[VC0]=8, empty[1]=1. A 9th push of 0xFF → ovf_err=1 and count stays 8.
- Pop VC0 eight times back-to-back → rd_data sequence 0..7, each one cycle after rd_en. rd_valid and credit_out[0] are high on 8 consecutive cycles. Then empty[0]=1.
- Interleave pushes of 20*i to VC0 and 100+i to VC1 (i=0..3), then pop alternately VC1/VC0 → 100,0,101,20,102,40,103,60 with rd_data_vc alternating 1,0. No cross-VC corruption.
- With 3 flits in VC1, push and pop VC1 in the same cycle for 10 cycles → count stays 3 and FIFO order is preserved across pointer wrap (ptr passes 7→0).
- Pop an empty VC0 while pushing 0xA5 to VC0 in the same cycle → rd_valid=0, udf_err=1, count[VC0]=1. Next-cycle pop returns 0xA5. Pulse err_clr → udf_err=0.
- Assert rst_n=0 asynchronously mid-burst, between clock edges, with 5 flits queued → all counts go to 0 and rd_valid drops to 0 at once, without waiting for a clock edge. After release, the first push/pop returns the new data.
